nmi_bus_demux: RTL and testbench
================================

NMI_BUS_DEMUX -- requirements
Module: nmi_bus_demux

Interface
REQ-001 SHALL have parameter NUM_SLV, default 12: number of NMI slave ports, range 1..16.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 255: maximum cycles waiting on slave ready, range 1..65535.
REQ-003 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on error completion.
REQ-004 SHALL have port clk_i, input, 1: single clock for all logic.
REQ-005 SHALL have port rst_n_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports m_valid_i (in, 1), m_addr_i (in, 32), m_wdata_i (in, 32), m_wstrb_i (in, 4): NMI master request.
REQ-007 SHALL have ports m_rdata_o (out, 32) and m_ready_o (out, 1): NMI master response.
REQ-008 SHALL have ports s_valid_o (out, NUM_SLV), s_addr_o (out, 32), s_wdata_o (out, 32), s_wstrb_o (out, 4): slave requests, payload shared by all slaves.
REQ-009 SHALL have ports s_rdata_i (in, NUM_SLV*32) and s_ready_i (in, NUM_SLV): slave responses, slave k at bits [32k+31:32k].
REQ-010 SHALL have ports map_base_i (in, NUM_SLV*32) and map_mask_i (in, NUM_SLV*32): static address map, normally tied to constants.
REQ-011 SHALL have ports err_clr_i (in, 1), err_irq_o (out, 1), err_addr_o (out, 32): bus-error reporting.

Function
REQ-012 SHALL match slave k when (m_addr_i & mask_k) == (base_k & mask_k); on multiple matches the lowest k wins.
REQ-013 SHALL implement FSM IDLE, DECODE, ACTIVE, ERR.
REQ-014 IDLE: on m_valid_i=1 -> DECODE; register one-hot select sel_q, addr, wdata and wstrb.
REQ-015 DECODE: if any slave matched -> ACTIVE; otherwise -> ERR.
REQ-016 ACTIVE: s_valid_o[k]=1 for selected k only; s_addr_o, s_wdata_o and s_wstrb_o driven from registered copies.
REQ-017 ACTIVE: m_ready_o = s_ready_i[k] (combinational); m_rdata_o = slave k rdata when m_ready_o=1, else 0; on s_ready_i[k]=1 -> IDLE.
REQ-018 ERR: m_ready_o=1 and m_rdata_o=ERR_RDATA for exactly one cycle; then -> IDLE.
REQ-019 Minimum latency m_valid_i to m_ready_o: 2 cycles with a zero-wait slave; 2 cycles for a decode miss.
REQ-020 Master holds request stable until m_ready_o and drops m_valid_i the cycle after; IDLE ignores m_valid_i in the cycle immediately following any completion.
REQ-021 Ready or valid asserted by an unselected slave SHALL be ignored.
REQ-022 On any error completion: err_irq_o sets to 1 (level) and err_addr_o captures the registered address.
REQ-023 err_clr_i=1 clears err_irq_o next cycle; a simultaneous new error wins (flag stays 1, address updates).
REQ-024 s_valid_o SHALL be 0 in IDLE, DECODE and ERR.

Reset
REQ-025 On rst_n_i=0, asynchronously: state=IDLE, sel_q=0, s_valid_o=0, m_ready_o=0, m_rdata_o=0, err_irq_o=0, err_addr_o=0, timeout counter=0, registered payload=0.
REQ-026 Reset mid-transaction SHALL abort it with no completion; the first request after release is decoded fresh.

Configuration
REQ-027 Macro NMI_DEMUX_TIMEOUT_EN defined: a 16-bit counter clears on ACTIVE entry and increments each ACTIVE cycle without ready. Reaching TIMEOUT_CYC drops s_valid_o and enters ERR, raising the error as in REQ-022. Ready on the same cycle the count reaches TIMEOUT_CYC wins, giving a normal completion.
REQ-028 Macro NMI_DEMUX_TIMEOUT_EN undefined: no counter; ACTIVE waits indefinitely; errors come from decode misses only.

Verification
REQ-029 NUM_SLV=3, slave1 base 32'h1000_0100 mask 32'hF000_FF00, zero-wait, rdata 32'h1234_5678; read 32'h1000_0104 -> s_valid_o=3'b010 one cycle, m_ready_o 2 cycles after valid, m_rdata_o=32'h1234_5678.
REQ-030 Write to 32'h7000_0000 (no match) -> no s_valid_o; m_ready_o with 32'hDEAD_BEEF after 2 cycles; err_irq_o=1; err_addr_o=32'h7000_0000.
REQ-031 Overlapping slaves 0 and 2 both match 32'h4000_0000 -> only s_valid_o[0] asserted.
REQ-032 With NMI_DEMUX_TIMEOUT_EN, TIMEOUT_CYC=8, slave never ready -> s_valid_o drops after 8 ACTIVE cycles; error completion; err_irq_o=1. Without the macro, valid stays high after 100 cycles.
REQ-033 err_clr_i pulsed in the same cycle as a new decode miss -> err_irq_o stays 1; err_addr_o shows the new address.
REQ-034 rst_n_i pulsed low during ACTIVE with a 5-wait slave -> all outputs 0 immediately; no m_ready_o; the next request completes normally.

Source files
------------

// File: rtl/nmi_bus_demux.sv
// -----------------------------------------------------------------------------
// nmi_bus_demux
//    Routes one NMI master onto NUM_SLV NMI slaves through a static base/mask
//    address map. Addresses that hit no slave complete with ERR_RDATA and
//    latch a level bus-error interrupt along with the offending address.
//
//    Optional build macro:
//       NMI_DEMUX_TIMEOUT_EN - abort a slave access that has not signalled
//                              ready within TIMEOUT_CYC cycles and complete
//                              it as a bus error.
//
//    Ports
//       clk_i, rst_n_i               clock, async active-low reset
//       m_valid_i/m_addr_i/
//       m_wdata_i/m_wstrb_i          master request
//       m_rdata_o/m_ready_o          master response
//       s_valid_o                    per-slave request strobe (one-hot)
//       s_addr_o/s_wdata_o/s_wstrb_o shared registered request payload
//       s_rdata_i/s_ready_i          slave responses, slave k at [32k+31:32k]
//       map_base_i/map_mask_i        address map, slave k at [32k+31:32k]
//       err_clr_i                    clears err_irq_o
//       err_irq_o/err_addr_o         bus-error flag and captured address
//
//    state  | meaning
//    -------+--------------------------------------------------------------
//    IDLE   | waiting for a master request; payload and select latched here
//    DECODE | select known; choose slave access or bus error
//    ACTIVE | selected slave strobed; completes on its ready
//    ERR    | one-cycle error completion with ERR_RDATA
// -----------------------------------------------------------------------------
module nmi_bus_demux #(
   parameter int          NUM_SLV     = 12,
   parameter int          TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   m_valid_i,
   input  logic [31:0]            m_addr_i,
   input  logic [31:0]            m_wdata_i,
   input  logic [3:0]             m_wstrb_i,
   output logic [31:0]            m_rdata_o,
   output logic                   m_ready_o,
   output logic [NUM_SLV-1:0]     s_valid_o,
   output logic [31:0]            s_addr_o,
   output logic [31:0]            s_wdata_o,
   output logic [3:0]             s_wstrb_o,
   input  logic [NUM_SLV*32-1:0]  s_rdata_i,
   input  logic [NUM_SLV-1:0]     s_ready_i,
   input  logic [NUM_SLV*32-1:0]  map_base_i,
   input  logic [NUM_SLV*32-1:0]  map_mask_i,
   input  logic                   err_clr_i,
   output logic                   err_irq_o,
   output logic [31:0]            err_addr_o
);

   if (NUM_SLV < 1 || NUM_SLV > 16) begin : g_bad_num_slv
      $error("nmi_bus_demux: NUM_SLV out of range 1..16");
   end
   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
      $error("nmi_bus_demux: TIMEOUT_CYC out of range 1..65535");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DECODE = 2'd1,
      ST_ACTIVE = 2'd2,
      ST_ERR    = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [NUM_SLV-1:0]   r_sel;
   logic [NUM_SLV-1:0]   w_match;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [3:0]           r_wstrb;
   logic                 r_cmpl;
   logic                 r_err_irq;
   logic [31:0]          r_err_addr;
   logic                 w_load;
   logic                 w_set_err;
   logic                 w_slv_ready;
   logic [31:0]          w_slv_rdata;

   // Iterating from the top down lets the lowest matching index overwrite.
   always_comb begin
      w_match = '0;
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
         if ((m_addr_i & map_mask_i[32*k +: 32]) ==
             (map_base_i[32*k +: 32] & map_mask_i[32*k +: 32])) begin
            w_match    = '0;
            w_match[k] = 1'b1;
         end
      end
   end

   // r_sel is one-hot, so masking keeps ready/rdata of other slaves out.
   assign w_slv_ready = |(r_sel & s_ready_i);

   always_comb begin
      w_slv_rdata = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (r_sel[k]) begin
            w_slv_rdata = w_slv_rdata | s_rdata_i[32*k +: 32];
         end
      end
   end

`ifdef NMI_DEMUX_TIMEOUT_EN
   logic [15:0] r_tmo_cnt;
   logic        w_tmo_hit;

   // Last ACTIVE cycle without ready: the count reaches TIMEOUT_CYC here.
   assign w_tmo_hit = (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ST_DECODE) begin
         r_tmo_cnt <= '0;
      end else if (r_state == ST_ACTIVE && !w_slv_ready) begin
         r_tmo_cnt <= r_tmo_cnt + 16'd1;
      end
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_set_err   = 1'b0;
      m_ready_o   = 1'b0;
      m_rdata_o   = '0;
      s_valid_o   = '0;
      case (r_state)
         ST_IDLE: begin
            // The master still holds valid in the cycle after a completion.
            if (m_valid_i && !r_cmpl) begin
               w_load      = 1'b1;
               w_state_nxt = ST_DECODE;
            end
         end
         ST_DECODE: begin
            w_state_nxt = (|r_sel) ? ST_ACTIVE : ST_ERR;
         end
         ST_ACTIVE: begin
            s_valid_o = r_sel;
            m_ready_o = w_slv_ready;
            if (w_slv_ready) begin
               m_rdata_o   = w_slv_rdata;
               w_state_nxt = ST_IDLE;
            end
`ifdef NMI_DEMUX_TIMEOUT_EN
            else if (w_tmo_hit) begin
               w_state_nxt = ST_ERR;
            end
`endif
         end
         ST_ERR: begin
            m_ready_o   = 1'b1;
            m_rdata_o   = ERR_RDATA;
            w_set_err   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_sel      <= '0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_cmpl     <= 1'b0;
         r_err_irq  <= 1'b0;
         r_err_addr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cmpl  <= m_ready_o;
         if (w_load) begin
            r_sel   <= w_match;
            r_addr  <= m_addr_i;
            r_wdata <= m_wdata_i;
            r_wstrb <= m_wstrb_i;
         end
         // A new error takes priority over a simultaneous clear.
         if (w_set_err) begin
            r_err_irq  <= 1'b1;
            r_err_addr <= r_addr;
         end else if (err_clr_i) begin
            r_err_irq  <= 1'b0;
         end
      end
   end

   assign s_addr_o   = r_addr;
   assign s_wdata_o  = r_wdata;
   assign s_wstrb_o  = r_wstrb;
   assign err_irq_o  = r_err_irq;
   assign err_addr_o = r_err_addr;

endmodule

// File: tb/tb_nmi_bus_demux.sv
module tb_nmi_bus_demux;

   localparam int NS  = 3;
   localparam int TMO = 8;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                m_valid;
   logic [31:0]         m_addr;
   logic [31:0]         m_wdata;
   logic [3:0]          m_wstrb;
   logic [31:0]         m_rdata_o;
   logic                m_ready_o;
   logic [NS-1:0]       s_valid_o;
   logic [31:0]         s_addr_o;
   logic [31:0]         s_wdata_o;
   logic [3:0]          s_wstrb_o;
   logic [NS*32-1:0]    s_rdata;
   logic [NS-1:0]       s_ready;
   logic [NS*32-1:0]    map_base;
   logic [NS*32-1:0]    map_mask;
   logic                err_clr;
   logic                err_irq_o;
   logic [31:0]         err_addr_o;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // slave0 4000_0xxx, slave1 1xxx_01xx, slave2 40xx_xxxx (overlaps slave0)
   assign map_base = {32'h4000_0000, 32'h1000_0100, 32'h4000_0000};
   assign map_mask = {32'hFF00_0000, 32'hF000_FF00, 32'hFFFF_F000};
   assign s_rdata  = {32'hCCCC_2222, 32'h1234_5678, 32'hAAAA_0000};

   nmi_bus_demux #(.NUM_SLV(NS), .TIMEOUT_CYC(TMO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .m_valid_i  (m_valid),
      .m_addr_i   (m_addr),
      .m_wdata_i  (m_wdata),
      .m_wstrb_i  (m_wstrb),
      .m_rdata_o  (m_rdata_o),
      .m_ready_o  (m_ready_o),
      .s_valid_o  (s_valid_o),
      .s_addr_o   (s_addr_o),
      .s_wdata_o  (s_wdata_o),
      .s_wstrb_o  (s_wstrb_o),
      .s_rdata_i  (s_rdata),
      .s_ready_i  (s_ready),
      .map_base_i (map_base),
      .map_mask_i (map_mask),
      .err_clr_i  (err_clr),
      .err_irq_o  (err_irq_o),
      .err_addr_o (err_addr_o)
   );

   // Slave model: ready once strobed for wait_cyc cycles; rogue forces ready.
   int            wait_cyc [NS];
   int            scnt     [NS];
   logic [NS-1:0] rogue_rdy;

   always_comb begin
      for (int k = 0; k < NS; k++) begin
         s_ready[k] = (s_valid_o[k] && (scnt[k] >= wait_cyc[k])) || rogue_rdy[k];
      end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NS; k++) begin
         if (s_valid_o[k] && !s_ready[k]) scnt[k] <= scnt[k] + 1;
         else                             scnt[k] <= 0;
      end
   end

   typedef struct {
      logic [31:0]   addr;
      logic [31:0]   rdata;
      int            lat;
      logic [NS-1:0] sel;
      int            nval;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   bit            obs_got;
   int            obs_lat;
   logic [31:0]   obs_rdata;
   int            obs_nval;
   logic [NS-1:0] obs_sel;
   logic [31:0]   obs_saddr;
   logic [31:0]   obs_swdata;
   logic [3:0]    obs_swstrb;
   bit            obs_spur;

   // Drives one request, records what the DUT does; comparisons are in tests.
   task automatic run_req(input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int budget, input bit clr_at_done);
      @(negedge clk);
      m_valid = 1'b1; m_addr = a; m_wdata = wd; m_wstrb = ws;
      obs_got = 0; obs_lat = 0; obs_rdata = '0; obs_nval = 0; obs_sel = '0;
      obs_saddr = '0; obs_swdata = '0; obs_swstrb = '0; obs_spur = 0;
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         if (s_valid_o != '0) begin
            obs_nval++;
            obs_sel    = obs_sel | s_valid_o;
            obs_saddr  = s_addr_o;
            obs_swdata = s_wdata_o;
            obs_swstrb = s_wstrb_o;
         end
         if (m_ready_o) begin
            obs_got   = 1;
            obs_lat   = c;
            obs_rdata = m_rdata_o;
            break;
         end
      end
      if (obs_got && clr_at_done) err_clr = 1'b1;
      @(posedge clk); #1;
      err_clr = 1'b0;
      m_valid = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         if (s_valid_o != '0 || m_ready_o) obs_spur = 1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
      err_clr = 1'b0; rogue_rdy = '0;
      for (int k = 0; k < NS; k++) wait_cyc[k] = 0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (s_valid_o !== '0 || m_ready_o !== 1'b0 || m_rdata_o !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: s_valid=%b m_ready=%b m_rdata=%h, want 0/0/0", s_valid_o, m_ready_o, m_rdata_o);
      end
      n_tests++;
      if (err_irq_o !== 1'b0 || err_addr_o !== '0 || s_addr_o !== '0) begin
         n_fail++;
         $display("FAIL reset_err: irq=%b err_addr=%h s_addr=%h, want 0", err_irq_o, err_addr_o, s_addr_o);
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic check_txn(input string nm);
      e = sb.pop_front();
      n_tests++;
      if (!obs_got) begin
         n_fail++;
         $display("FAIL %s_timeout: no m_ready_o within budget (addr %h)", nm, e.addr);
      end else begin
         if (obs_rdata !== e.rdata || obs_lat != e.lat) begin
            n_fail++;
            $display("FAIL %s_resp: rdata=%h lat=%0d, want rdata=%h lat=%0d", nm, obs_rdata, obs_lat, e.rdata, e.lat);
         end
      end
      n_tests++;
      if (obs_sel !== e.sel || obs_nval != e.nval || obs_spur) begin
         n_fail++;
         $display("FAIL %s_strobe: s_valid=%b cycles=%0d spurious=%0d, want %b cycles=%0d spurious=0",
                  nm, obs_sel, obs_nval, obs_spur, e.sel, e.nval);
      end
   endtask

   task automatic test_read_hit();
      sb.push_back('{32'h1000_0104, 32'h1234_5678, 2, 3'b010, 1});
      run_req(32'h1000_0104, 32'h0, 4'h0, 20, 0);
      check_txn("read_hit");
      n_tests++;
      if (obs_saddr !== 32'h1000_0104) begin
         n_fail++;
         $display("FAIL read_hit_addr: s_addr=%h, want 10000104", obs_saddr);
      end
   endtask

   task automatic test_write_payload();
      wait_cyc[2] = 2;
      sb.push_back('{32'h4001_0010, 32'hCCCC_2222, 4, 3'b100, 3});
      run_req(32'h4001_0010, 32'hA5A5_0F0F, 4'b0101, 20, 0);
      check_txn("write_slv2");
      n_tests++;
      if (obs_swdata !== 32'hA5A5_0F0F || obs_swstrb !== 4'b0101 || obs_saddr !== 32'h4001_0010) begin
         n_fail++;
         $display("FAIL write_payload: addr=%h wdata=%h wstrb=%b, want 40010010 a5a50f0f 0101",
                  obs_saddr, obs_swdata, obs_swstrb);
      end
      wait_cyc[2] = 0;
   endtask

   task automatic test_decode_miss();
      sb.push_back('{32'h7000_0000, 32'hDEAD_BEEF, 2, 3'b000, 0});
      run_req(32'h7000_0000, 32'h1111_2222, 4'hF, 20, 0);
      check_txn("miss");
      n_tests++;
      if (err_irq_o !== 1'b1 || err_addr_o !== 32'h7000_0000) begin
         n_fail++;
         $display("FAIL miss_err: irq=%b err_addr=%h, want 1 70000000", err_irq_o, err_addr_o);
      end
   endtask

   task automatic test_overlap();
      sb.push_back('{32'h4000_0000, 32'hAAAA_0000, 2, 3'b001, 1});
      run_req(32'h4000_0000, 32'h0, 4'h0, 20, 0);
      check_txn("overlap");
   endtask

   task automatic test_ignore_unselected();
      wait_cyc[1] = 3;
      rogue_rdy   = 3'b101;
      sb.push_back('{32'h1ABC_0120, 32'h1234_5678, 5, 3'b010, 4});
      run_req(32'h1ABC_0120, 32'h0, 4'h0, 20, 0);
      rogue_rdy   = '0;
      wait_cyc[1] = 0;
      check_txn("unselected");
   endtask

   task automatic test_err_clr();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      n_tests++;
      if (err_irq_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clr_only: irq=%b, want 0", err_irq_o);
      end
      sb.push_back('{32'h7000_0010, 32'hDEAD_BEEF, 2, 3'b000, 0});
      run_req(32'h7000_0010, 32'h0, 4'h0, 20, 0);
      check_txn("miss2");
      sb.push_back('{32'h7000_0020, 32'hDEAD_BEEF, 2, 3'b000, 0});
      run_req(32'h7000_0020, 32'h0, 4'h0, 20, 1);
      check_txn("miss_clr");
      n_tests++;
      if (err_irq_o !== 1'b1 || err_addr_o !== 32'h7000_0020) begin
         n_fail++;
         $display("FAIL clr_vs_new_err: irq=%b err_addr=%h, want 1 70000020", err_irq_o, err_addr_o);
      end
   endtask

   task automatic test_timeout();
      @(negedge clk); err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      wait_cyc[1] = 100000;
`ifdef NMI_DEMUX_TIMEOUT_EN
      sb.push_back('{32'h1000_0108, 32'hDEAD_BEEF, 2 + TMO, 3'b010, TMO});
      run_req(32'h1000_0108, 32'h0, 4'h0, 40, 0);
      check_txn("timeout");
      n_tests++;
      if (err_irq_o !== 1'b1 || err_addr_o !== 32'h1000_0108) begin
         n_fail++;
         $display("FAIL timeout_err: irq=%b err_addr=%h, want 1 10000108", err_irq_o, err_addr_o);
      end
`else
      begin
         bit got = 0;
         logic [31:0] rd = '0;
         @(negedge clk);
         m_valid = 1'b1; m_addr = 32'h1000_0108; m_wdata = '0; m_wstrb = '0;
         repeat (102) @(posedge clk);
         #1;
         n_tests++;
         if (s_valid_o !== 3'b010 || m_ready_o !== 1'b0 || m_rdata_o !== '0) begin
            n_fail++;
            $display("FAIL no_timeout_wait: s_valid=%b m_ready=%b m_rdata=%h, want 010 0 0", s_valid_o, m_ready_o, m_rdata_o);
         end
         wait_cyc[1] = 0;
         for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (m_ready_o) begin got = 1; rd = m_rdata_o; break; end
         end
         @(posedge clk); #1;
         m_valid = 1'b0;
         n_tests++;
         if (!got || rd !== 32'h1234_5678 || err_irq_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_timeout_done: got=%0d rdata=%h irq=%b, want 1 12345678 0", got, rd, err_irq_o);
         end
      end
`endif
      wait_cyc[1] = 0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit seen_rdy = 0;
      wait_cyc[1] = 5;
      @(negedge clk);
      m_valid = 1'b1; m_addr = 32'h1000_0104; m_wdata = '0; m_wstrb = '0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if (s_valid_o !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_mid_active: s_valid=%b, want 010", s_valid_o);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (s_valid_o !== '0 || m_ready_o !== 1'b0 || m_rdata_o !== '0 || err_irq_o !== 1'b0 || err_addr_o !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: s_valid=%b m_ready=%b rdata=%h irq=%b err_addr=%h, want all 0",
                  s_valid_o, m_ready_o, m_rdata_o, err_irq_o, err_addr_o);
      end
      m_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (m_ready_o) seen_rdy = 1;
         if (c == 2) rst_n = 1'b1;
      end
      n_tests++;
      if (seen_rdy) begin
         n_fail++;
         $display("FAIL rst_mid_abort: m_ready_o seen after reset, want none");
      end
      sb.push_back('{32'h1000_0104, 32'h1234_5678, 7, 3'b010, 6});
      run_req(32'h1000_0104, 32'h0, 4'h0, 20, 0);
      check_txn("after_reset");
      wait_cyc[1] = 0;
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [6];
      logic [31:0] rds   [6];
      logic [NS-1:0] sels [6];
      int          w [3];
      addrs = '{32'h4000_0FFC, 32'h1F00_01F0, 32'h40FF_0000, 32'h8000_0000, 32'h4000_1000, 32'h1000_0200};
      rds   = '{32'hAAAA_0000, 32'h1234_5678, 32'hCCCC_2222, 32'hDEAD_BEEF, 32'hCCCC_2222, 32'hDEAD_BEEF};
      sels  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b100, 3'b000};
      w     = '{1, 0, 2};
      for (int k = 0; k < NS; k++) wait_cyc[k] = w[k];
      for (int i = 0; i < 6; i++) begin
         int wt = 0;
         int nv = 0;
         for (int k = 0; k < NS; k++) if (sels[i][k]) begin wt = w[k]; nv = w[k] + 1; end
         sb.push_back('{addrs[i], rds[i], 2 + wt, sels[i], nv});
         run_req(addrs[i], $urandom, 4'($urandom_range(0, 15)), 20, 0);
         check_txn("b2b");
      end
      n_tests++;
      if (err_irq_o !== 1'b1 || err_addr_o !== 32'h1000_0200) begin
         n_fail++;
         $display("FAIL b2b_err: irq=%b err_addr=%h, want 1 10000200", err_irq_o, err_addr_o);
      end
      for (int k = 0; k < NS; k++) wait_cyc[k] = 0;
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_payload();
      test_decode_miss();
      test_overlap();
      test_ignore_unselected();
      test_err_clr();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
